shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter NBits, default 16, product width; operand width is NBits/2; NBits SHALL be even and at least 4.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiplication; sampled only when ready=1.
REQ-005 SHALL have port multiplicand, input, NBits/2, unsigned operand A; zero-extended to NBits on load.
REQ-006 SHALL have port multiplier, input, NBits/2, unsigned operand B.
REQ-007 SHALL have port product, output, NBits, registered unsigned A*B.
REQ-008 SHALL have port ready, output, 1, high in IDLE only.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking product valid.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE; ready, done and product SHALL be decoded from registered state only.
REQ-011 IDLE: on an edge with start=1, SHALL load mcand_reg={zeros, multiplicand} (NBits wide), mplier_reg=multiplier, acc=0, count=0; next state RUN.
REQ-012 IDLE with start=0: SHALL hold all registers; product SHALL keep its last value.
REQ-013 RUN, each edge: if mplier_reg[0]=1 then acc=acc+mcand_reg (NBits modulo, no carry-out needed); mcand_reg shifted left 1; mplier_reg shifted right 1; count incremented.
REQ-014 RUN SHALL last exactly NBits/2 edges; on the last RUN edge product SHALL load the final acc, and next state SHALL be DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-016 Latency: with start sampled at edge k, done SHALL be high from edge k+NBits/2 to edge k+NBits/2+1 (16-bit default: 8 cycles after the start edge).
REQ-017 start during RUN or DONE SHALL be ignored and SHALL NOT be queued; operand changes after the start edge SHALL NOT affect the result.
REQ-018 Back-to-back operation: start high in the first IDLE cycle after DONE SHALL be accepted.
REQ-019 Operand 0 on either input SHALL produce product=0 with the normal latency, unless REQ-025 applies.

Reset
REQ-020 Assertion of reset (low) SHALL immediately and asynchronously force state=IDLE, acc=0, mcand_reg=0, mplier_reg=0, count=0, and product=0.
REQ-021 During and after reset, outputs SHALL be ready=1, done=0, product=0.
REQ-022 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL proceed normally.
REQ-023 Reset release SHALL take effect on the first rising clk edge with reset=1.

Configuration
REQ-024 Macro EARLY_EXIT_EN SHALL select early termination.
REQ-025 When EARLY_EXIT_EN is defined: on a RUN edge where the shifted mplier_reg becomes 0, product SHALL load acc including that edge's add, and next state SHALL be DONE; RUN lasts at least 1 and at most NBits/2 edges.
REQ-026 When EARLY_EXIT_EN is not defined: latency SHALL be fixed per REQ-016, and no zero-detect logic SHALL be present.

Verification
REQ-027 Directed scenario: NBits=16, A=0xFF, B=0xFF, start at edge k -> done high at edge k+8; product=0xFE01; ready low during edges k+1..k+8.
REQ-028 Directed scenario: A=0x0D, B=0x03 -> product=0x0027. Without EARLY_EXIT_EN, done at k+8. With EARLY_EXIT_EN, done at k+2.
REQ-029 Directed scenario: A=0x12, B=0x00 -> product=0x0000. Without EARLY_EXIT_EN, done at k+8. With EARLY_EXIT_EN, done at k+1.
REQ-030 Directed scenario: start with A=0x05, B=0x07; then pulse start with A=0xFF, B=0xFF at k+3 -> product=0x0023; exactly one done pulse.
REQ-031 Directed scenario: start with A=0xAA, B=0x55; assert reset at k+4 -> product=0, ready=1, no done; then after release A=0x02, B=0x03 -> product=0x0006.
REQ-032 Directed scenario: A=0x10, B=0x10 with start held high continuously -> done pulses every 10 cycles, each with product=0x0100.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Purpose:
//    Sequential unsigned multiplier that uses the shift-and-add method.
//    Each cycle in RUN it takes one multiplier bit, LSB first. If that bit
//    is 1, the left-shifted multiplicand is added into an accumulator.
//    The product is registered on the last RUN edge. done pulses for one
//    cycle (DONE state), and then the block returns to IDLE.
//
// Parameters:
//    NBits         product width. Each operand is NBits/2 wide.
//                  NBits must be even and >= 4.
//
// Ports:
//    clk           single clock; all state changes on its rising edge
//    reset         asynchronous active-low reset
//    start         begin a multiplication (sampled only while ready=1)
//    multiplicand  unsigned operand A, NBits/2 bits
//    multiplier    unsigned operand B, NBits/2 bits
//    product       registered A*B, NBits bits (held until next result)
//    ready         high in IDLE only
//    done          one-cycle pulse while the new product is valid
//
// Configuration macro:
//    EARLY_EXIT_EN  when defined, RUN ends as soon as the remaining
//                   multiplier bits are all zero. Undefined (default):
//                   RUN always takes exactly NBits/2 cycles.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
   parameter int NBits = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NBits/2-1:0]   multiplicand,
   input  logic [NBits/2-1:0]   multiplier,
   output logic [NBits-1:0]     product,
   output logic                 ready,
   output logic                 done
);

   localparam int W  = NBits / 2;
   // The count only has to reach W-1, and W >= 2, so clog2(W) bits suffice.
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [NBits-1:0]    acc_reg;
   logic [NBits-1:0]    mcand_reg;
   logic [NBits-1:0]    product_reg;
   logic [W-1:0]        mplier_reg;
   logic [CW-1:0]       count_reg;

   logic [NBits-1:0]    acc_sum;
   logic [W-1:0]        mplier_shift;
   logic                last_edge;

   // Accumulator value after this edge's conditional add. The addition
   // wraps modulo 2^NBits; the true product always fits, so no carry-out.
   always_comb begin
      acc_sum      = acc_reg;
      if (mplier_reg[0]) begin
         acc_sum = acc_reg + mcand_reg;
      end
      mplier_shift = mplier_reg >> 1;
   end

   // last_edge marks the final RUN edge: the product is captured there.
`ifdef EARLY_EXIT_EN
   // Stop early once no multiplier bits remain to be consumed.
   always_comb begin
      last_edge = (count_reg == CW'(W - 1)) || (mplier_shift == '0);
   end
`else
   always_comb begin
      last_edge = (count_reg == CW'(W - 1));
   end
`endif

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_edge) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         count_reg   <= '0;
         product_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  // The operands are captured here. Later changes on the
                  // input pins have no effect on this operation.
                  acc_reg    <= '0;
                  mcand_reg  <= {{W{1'b0}}, multiplicand};
                  mplier_reg <= multiplier;
                  count_reg  <= '0;
               end
            end
            RUN: begin
               acc_reg    <= acc_sum;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_shift;
               count_reg  <= count_reg + CW'(1);
               if (last_edge) begin
                  product_reg <= acc_sum;
               end
            end
            default: begin
               // DONE: all registers hold their values.
            end
         endcase
      end
   end

   assign product = product_reg;
   assign ready   = (state_reg == IDLE);
   assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Self-checking bench for shift_add_multiplier with the default NBits=16.
// Expected products are plain integer multiplication. Expected latency is
// NBits/2, or, when EARLY_EXIT_EN is defined, the position of the
// multiplier's highest set bit (minimum 1).
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

   localparam int NB = 16;
   localparam int W  = NB / 2;

   logic            clk;
   logic            reset;
   logic            start;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic [NB-1:0]   product;
   logic            ready;
   logic            done;

   int tests_run;
   int tests_failed;

   shift_add_multiplier #(.NBits(NB)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .ready        (ready),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [NB-1:0] p;
   } vec_t;

   vec_t vecs[8];

   // Reference latency, in edges from the start edge to the done edge.
   function automatic int exp_lat(input logic [W-1:0] b);
      int l;
`ifdef EARLY_EXIT_EN
      l = 1;
      for (int i = 0; i < W; i++) begin
         if (b[i]) l = i + 1;
      end
`else
      l = W;
`endif
      return l;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Run one multiplication. The operands are scrambled right after the
   // start edge, so the result must come from the captured values.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [NB-1:0] exp_p, input string name);
      int lat;
      bit got;
      logic [NB-1:0] held;
      lat = 0;
      got = 0;
      @(negedge clk);
      check({name, "_ready_before"}, {31'd0, ready}, 32'd1);
      start = 1'b1;
      multiplicand = a;
      multiplier = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      multiplicand = W'($urandom);
      multiplier = W'($urandom);
      check({name, "_ready_run"}, {31'd0, ready}, 32'd0);
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got = 1;
            lat = i;
         end
      end
      check({name, "_done_seen"}, {31'd0, got}, 32'd1);
      check({name, "_latency"}, lat, exp_lat(b));
      check({name, "_product"}, {16'd0, product}, {16'd0, exp_p});
      held = product;
      @(posedge clk);
      #1;
      check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({name, "_ready_after"}, {31'd0, ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check({name, "_hold"}, {16'd0, product}, {16'd0, held});
      $display("[TB] op %s a=0x%0h b=0x%0h product=0x%0h latency=%0d", name, a, b, product, lat);
   endtask

   initial begin
      int ndone;
      int first_lat;
      int prev;
      int exp_cnt;
      int l;
      logic [NB-1:0] pd;
      logic [W-1:0] ra, rb;

      tests_run = 0;
      tests_failed = 0;

      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[1] = '{8'h0D, 8'h03, 16'h0027};
      vecs[2] = '{8'h12, 8'h00, 16'h0000};
      vecs[3] = '{8'h00, 8'hFF, 16'h0000};
      vecs[4] = '{8'h01, 8'h01, 16'h0001};
      vecs[5] = '{8'hFF, 8'h80, 16'h7F80};
      vecs[6] = '{8'h80, 8'h01, 16'h0080};
      vecs[7] = '{8'hAB, 8'hCD, 16'h88EF};

      // Outputs while reset is held
      reset = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      #12;
      check("reset_ready", {31'd0, ready}, 32'd1);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_product", {16'd0, product}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("release_ready", {31'd0, ready}, 32'd1);

      // Table-driven vectors
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
      end

      // A start arriving during RUN is ignored, not queued.
      @(negedge clk);
      start = 1'b1;
      multiplicand = 8'h05;
      multiplier = 8'h07;
      ndone = 0;
      first_lat = 0;
      pd = '0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         if (i == 3) begin
            @(negedge clk);
            start = 1'b1;
            multiplicand = 8'hFF;
            multiplier = 8'hFF;
         end
         @(posedge clk);
         #1;
         if (i == 3) start = 1'b0;
         if (done) begin
            ndone++;
            if (first_lat == 0) begin
               first_lat = i;
               pd = product;
            end
         end
      end
      check("ignore_done_count", ndone, 1);
      check("ignore_latency", first_lat, exp_lat(8'h07));
      check("ignore_product", {16'd0, pd}, 32'h0023);
      $display("[TB] op ignore_start product=0x%0h dones=%0d", pd, ndone);

      // Reset in the middle of RUN aborts the operation.
      @(negedge clk);
      start = 1'b1;
      multiplicand = 8'hAA;
      multiplier = 8'h55;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("midrun_reset_ready", {31'd0, ready}, 32'd1);
      check("midrun_reset_product", {16'd0, product}, 32'd0);
      check("midrun_reset_done", {31'd0, done}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("midrun_reset_no_done", ndone, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_product", {16'd0, product}, 32'd0);
      check("post_reset_done", {31'd0, done}, 32'd0);
      $display("[TB] op midrun_reset product=0x%0h ready=%0d", product, ready);
      run_op(8'h02, 8'h03, 16'h0006, "after_reset");

      // start held high: back-to-back operations
      @(negedge clk);
      start = 1'b1;
      multiplicand = 8'h10;
      multiplier = 8'h10;
      l = exp_lat(8'h10);
      ndone = 0;
      prev = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            check("b2b_product", {16'd0, product}, 32'h0100);
            if (prev == 0) check("b2b_first_latency", i - 1, l);
            else           check("b2b_period", i - prev, l + 2);
            prev = i;
         end
      end
      start = 1'b0;
      exp_cnt = 0;
      for (int n = 0; 1 + l + n * (l + 2) <= 40; n++) exp_cnt++;
      check("b2b_done_count", ndone, exp_cnt);
      $display("[TB] op back_to_back dones=%0d", ndone);
      repeat (W + 4) @(posedge clk);
      #1;
      check("b2b_drain_ready", {31'd0, ready}, 32'd1);

      // Random operands against the reference model
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = W'($urandom_range(0, 255));
         if (i % 5 == 0) rb = W'(rb >> $urandom_range(0, 7));
         run_op(ra, rb, NB'(ra) * NB'(rb), $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog: a hung run still reaches a failure line and ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
